// File: rtl/recirc_reinject_if.sv
// Bundle of the main-path, recirculation and merged-output signals of recirc_reinject.
// The master side is the traffic source; the slave side is the re-inject block.
interface recirc_reinject_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in0;
  logic [WIDTH-1:0] data_in1;
  logic [WIDTH-1:0] data_in2;
  logic [WIDTH-1:0] data_in3;
  logic             valid_in;
  logic [WIDTH-1:0] data_rc0;
  logic [WIDTH-1:0] data_rc1;
  logic [WIDTH-1:0] data_rc2;
  logic [WIDTH-1:0] data_rc3;
  logic             valid_rc;
  logic [WIDTH-1:0] data_out0;
  logic [WIDTH-1:0] data_out1;
  logic [WIDTH-1:0] data_out2;
  logic [WIDTH-1:0] data_out3;
  logic             valid_out;
  logic             src_rc;
  logic             fifo_full;
  logic             fifo_empty;
  logic             overflow;
  logic             stall_main;

  modport master (
    output data_in0, data_in1, data_in2, data_in3, valid_in,
    output data_rc0, data_rc1, data_rc2, data_rc3, valid_rc,
    input  data_out0, data_out1, data_out2, data_out3, valid_out,
    input  src_rc, fifo_full, fifo_empty, overflow, stall_main
  );

  modport slave (
    input  data_in0, data_in1, data_in2, data_in3, valid_in,
    input  data_rc0, data_rc1, data_rc2, data_rc3, valid_rc,
    output data_out0, data_out1, data_out2, data_out3, valid_out,
    output src_rc, fifo_full, fifo_empty, overflow, stall_main
  );
endinterface

// File: rtl/recirc_reinject.sv
// Queues diverted 4-lane words and re-injects them into the main stream when it idles.
// Optional macro RECIRC_STARVE_EN adds a starvation counter that forces a re-inject.
module recirc_reinject #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 4,
  parameter int AW         = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic             clk,
  input  logic             reset_L,
  recirc_reinject_if.slave bus
);
  localparam int                  WW       = 4 * WIDTH;
  localparam logic [AW:0]         FULL_CNT = (AW + 1)'(DEPTH);

  if (DEPTH != (1 << AW)) begin : g_bad_depth
    $error("recirc_reinject: DEPTH must equal 2**AW");
  end
  if (STARVE_MAX < 1) begin : g_bad_starve
    $error("recirc_reinject: STARVE_MAX must be at least 1");
  end

  // Handshake: valid-only streams. A main word is accepted on any edge where
  // valid_in=1 and stall_main=0; during stall_main=1 the source holds its word.
  // valid_rc is a push request and is never back-pressured (excess is dropped).

  logic [WW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [WW-1:0] data_out_q;
  logic          valid_out_q;
  logic          src_rc_q;
  logic          overflow_q;

  logic [WW-1:0] main_word, rc_word, head_word;
  logic          fifo_full, fifo_empty;
  logic          stall_main;
  logic          pop, push, main_take;

  assign main_word  = {bus.data_in3, bus.data_in2, bus.data_in1, bus.data_in0};
  assign rc_word    = {bus.data_rc3, bus.data_rc2, bus.data_rc1, bus.data_rc0};
  assign head_word  = mem_q[rd_ptr_q];

  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);

  assign main_take  = bus.valid_in && !stall_main;
  assign pop        = !fifo_empty && (!bus.valid_in || stall_main);
  assign push       = bus.valid_rc && (!fifo_full || pop);

`ifdef RECIRC_STARVE_EN
  localparam int              SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);

  logic [SW-1:0] starve_q, starve_d;

  assign stall_main = (starve_q == STARVE_LIM) && !fifo_empty;

  always_comb begin
    starve_d = starve_q;
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (bus.valid_in && !stall_main && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign stall_main = 1'b0;
`endif

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset; the pointers and count alone define what is queued.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= rc_word;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      src_rc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (bus.valid_rc && fifo_full && !pop) begin
        overflow_q <= 1'b1;
      end
      // Main path wins whenever it is not stalled; the FIFO only fills idle slots.
      if (main_take) begin
        data_out_q  <= main_word;
        valid_out_q <= 1'b1;
        src_rc_q    <= 1'b0;
      end else if (pop) begin
        data_out_q  <= head_word;
        valid_out_q <= 1'b1;
        src_rc_q    <= 1'b1;
      end else begin
        data_out_q  <= '0;
        valid_out_q <= 1'b0;
        src_rc_q    <= 1'b0;
      end
    end
  end

  assign bus.data_out0  = data_out_q[WIDTH-1:0];
  assign bus.data_out1  = data_out_q[2*WIDTH-1:WIDTH];
  assign bus.data_out2  = data_out_q[3*WIDTH-1:2*WIDTH];
  assign bus.data_out3  = data_out_q[4*WIDTH-1:3*WIDTH];
  assign bus.valid_out  = valid_out_q;
  assign bus.src_rc     = src_rc_q;
  assign bus.fifo_full  = fifo_full;
  assign bus.fifo_empty = fifo_empty;
  assign bus.overflow   = overflow_q;
  assign bus.stall_main = stall_main;
endmodule

// File: tb/tb_recirc_reinject.sv
// Directed bench for recirc_reinject: stimulus pushes expected output words into a
// queue, a negedge monitor pops and compares every valid output word.
module tb_recirc_reinject;
  localparam int W = 8;

  logic clk;
  logic reset_L;
  int   checks;
  int   errors;

  // Expected entry: {src_rc, lane3, lane2, lane1, lane0}
  logic [4*W:0] exp_q[$];

  recirc_reinject_if #(.WIDTH(W)) bus ();

  recirc_reinject #(
    .WIDTH(W), .DEPTH(4), .AW(2), .STARVE_MAX(3)
  ) dut (
    .clk    (clk),
    .reset_L(reset_L),
    .bus    (bus.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4*W-1:0] lanes(input logic [7:0] l0, input logic [7:0] l1,
                                           input logic [7:0] l2, input logic [7:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  // Driver tasks
  task automatic set_main(input logic v, input logic [4*W-1:0] w);
    bus.valid_in = v;
    {bus.data_in3, bus.data_in2, bus.data_in1, bus.data_in0} = w;
  endtask

  task automatic set_rc(input logic v, input logic [4*W-1:0] w);
    bus.valid_rc = v;
    {bus.data_rc3, bus.data_rc2, bus.data_rc1, bus.data_rc0} = w;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic src, input logic [4*W-1:0] w);
    exp_q.push_back({src, w});
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b required %b at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [4*W:0] got;
    logic [4*W:0] req;
    if (reset_L === 1'b1 && bus.valid_out === 1'b1) begin
      got = {bus.src_rc, bus.data_out3, bus.data_out2, bus.data_out1, bus.data_out0};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_word: got %h required no output at %0t", got, $time);
      end else begin
        req = exp_q.pop_front();
        if (got !== req) begin
          errors++;
          $display("FAIL out_word: got %h required %h at %0t", got, req, $time);
        end
      end
    end
  end

  initial begin
    logic [4*W-1:0] w_main;
    logic [4*W-1:0] w_rc;
    checks  = 0;
    errors  = 0;
    reset_L = 1'b0;
    set_main(1'b0, '0);
    set_rc(1'b0, '0);
    repeat (3) step();
    reset_L = 1'b1;
    step();

    // Reset state
    check_bit("rst_valid_out", bus.valid_out, 1'b0);
    check_bit("rst_fifo_empty", bus.fifo_empty, 1'b1);
    check_bit("rst_fifo_full", bus.fifo_full, 1'b0);
    check_bit("rst_overflow", bus.overflow, 1'b0);
    check_bit("rst_stall_main", bus.stall_main, 1'b0);

    // Re-inject on an idle main path: push edge, then pop edge
    w_rc = lanes(8'h11, 8'h22, 8'h33, 8'h44);
    set_rc(1'b1, w_rc);
    expect_word(1'b1, w_rc);
    step();
    set_rc(1'b0, '0);
    check_bit("reinj_no_bypass", bus.valid_out, 1'b0);
    check_bit("reinj_queued", bus.fifo_empty, 1'b0);
    step();
    check_bit("reinj_valid", bus.valid_out, 1'b1);
    check_bit("reinj_src", bus.src_rc, 1'b1);
    step();
    check_bit("reinj_after_valid", bus.valid_out, 1'b0);
    check_bit("reinj_after_empty", bus.fifo_empty, 1'b1);

    // Main path priority over a queued word
    w_main = lanes(8'hAA, 8'hAA, 8'hAA, 8'hAA);
    w_rc   = lanes(8'h55, 8'h66, 8'h77, 8'h88);
    set_main(1'b1, w_main);
    set_rc(1'b1, w_rc);
    for (int i = 0; i < 5; i++) begin
      expect_word(1'b0, w_main);
      step();
      set_rc(1'b0, '0);
      check_bit("prio_src", bus.src_rc, 1'b0);
      check_bit("prio_queued", bus.fifo_empty, 1'b0);
      check_bit("prio_stall", bus.stall_main, 1'b0);
    end
    set_main(1'b0, '0);
    expect_word(1'b1, w_rc);
    step();
    check_bit("prio_rc_src", bus.src_rc, 1'b1);
    step();
    check_bit("prio_end_valid", bus.valid_out, 1'b0);
    check_bit("prio_end_empty", bus.fifo_empty, 1'b1);

    // Overflow: five pushes into a 4-deep FIFO while main is busy
    w_main = lanes(8'hB0, 8'hB1, 8'hB2, 8'hB3);
    set_main(1'b1, w_main);
    for (int i = 1; i <= 5; i++) begin
      set_rc(1'b1, lanes(8'(i), 8'(i + 16), 8'(i + 32), 8'(i + 48)));
      expect_word(1'b0, w_main);
      step();
    end
    set_rc(1'b0, '0);
    check_bit("ovf_full", bus.fifo_full, 1'b1);
    check_bit("ovf_flag", bus.overflow, 1'b1);
    set_main(1'b0, '0);
    for (int i = 1; i <= 4; i++) begin
      expect_word(1'b1, lanes(8'(i), 8'(i + 16), 8'(i + 32), 8'(i + 48)));
    end
    repeat (4) step();
    step();
    check_bit("ovf_drained", bus.fifo_empty, 1'b1);
    check_bit("ovf_sticky", bus.overflow, 1'b1);
    check_bit("ovf_no_lost_word", bus.valid_out, 1'b0);

    // Asynchronous reset mid-drain with three words still queued
    w_main = lanes(8'hC0, 8'hC1, 8'hC2, 8'hC3);
    set_main(1'b1, w_main);
    for (int i = 0; i < 4; i++) begin
      set_rc(1'b1, lanes(8'(8'h60 + i), 8'h61, 8'h62, 8'h63));
      expect_word(1'b0, w_main);
      step();
    end
    set_rc(1'b0, '0);
    set_main(1'b0, '0);
    expect_word(1'b1, lanes(8'h60, 8'h61, 8'h62, 8'h63));
    step();
    @(negedge clk);
    #1;
    reset_L = 1'b0;
    #1;
    check_bit("midrst_valid_out", bus.valid_out, 1'b0);
    check_bit("midrst_empty", bus.fifo_empty, 1'b1);
    check_bit("midrst_overflow", bus.overflow, 1'b0);
    step();
    step();
    reset_L = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_bit("midrst_no_stale", bus.valid_out, 1'b0);
    end

    // Full FIFO: simultaneous push and pop keeps count at DEPTH
    w_main = lanes(8'hD0, 8'hD1, 8'hD2, 8'hD3);
    set_main(1'b1, w_main);
    for (int i = 0; i < 4; i++) begin
      set_rc(1'b1, lanes(8'(8'h70 + i), 8'h7A, 8'h7B, 8'h7C));
      expect_word(1'b0, w_main);
      step();
    end
    set_rc(1'b0, '0);
    check_bit("full_before", bus.fifo_full, 1'b1);
    check_bit("full_ovf_before", bus.overflow, 1'b0);
    set_main(1'b0, '0);
    set_rc(1'b1, lanes(8'h09, 8'h19, 8'h29, 8'h39));
    expect_word(1'b1, lanes(8'h70, 8'h7A, 8'h7B, 8'h7C));
    step();
    set_rc(1'b0, '0);
    check_bit("full_pp_full", bus.fifo_full, 1'b1);
    check_bit("full_pp_ovf", bus.overflow, 1'b0);
    check_bit("full_pp_src", bus.src_rc, 1'b1);
    for (int i = 1; i < 4; i++) begin
      expect_word(1'b1, lanes(8'(8'h70 + i), 8'h7A, 8'h7B, 8'h7C));
    end
    expect_word(1'b1, lanes(8'h09, 8'h19, 8'h29, 8'h39));
    repeat (4) step();
    step();
    check_bit("full_pp_drained", bus.fifo_empty, 1'b1);
    check_bit("full_pp_idle", bus.valid_out, 1'b0);

`ifdef RECIRC_STARVE_EN
    // Starvation: forced re-inject after STARVE_MAX main cycles with a word queued
    w_main = lanes(8'hE0, 8'hE1, 8'hE2, 8'hE3);
    w_rc   = lanes(8'hF0, 8'hF1, 8'hF2, 8'hF3);
    set_main(1'b1, w_main);
    set_rc(1'b1, w_rc);
    expect_word(1'b0, w_main);
    step();
    set_rc(1'b0, '0);
    check_bit("starve_stall_0", bus.stall_main, 1'b0);
    for (int i = 0; i < 3; i++) begin
      expect_word(1'b0, w_main);
      step();
      check_bit("starve_stall_n", bus.stall_main, (i == 2) ? 1'b1 : 1'b0);
    end
    expect_word(1'b1, w_rc);
    step();
    check_bit("starve_src", bus.src_rc, 1'b1);
    check_bit("starve_release", bus.stall_main, 1'b0);
    expect_word(1'b0, w_main);
    step();
    set_main(1'b0, '0);
    step();
    check_bit("starve_end_empty", bus.fifo_empty, 1'b1);
`else
    // Without the macro a queued word waits as long as main stays busy
    w_main = lanes(8'hE0, 8'hE1, 8'hE2, 8'hE3);
    w_rc   = lanes(8'hF0, 8'hF1, 8'hF2, 8'hF3);
    set_main(1'b1, w_main);
    set_rc(1'b1, w_rc);
    for (int i = 0; i < 6; i++) begin
      expect_word(1'b0, w_main);
      step();
      set_rc(1'b0, '0);
      check_bit("nostarve_stall", bus.stall_main, 1'b0);
    end
    set_main(1'b0, '0);
    expect_word(1'b1, w_rc);
    step();
    check_bit("nostarve_src", bus.src_rc, 1'b1);
    step();
    check_bit("nostarve_empty", bus.fifo_empty, 1'b1);
`endif

    // Every expected word must have been seen
    repeat (3) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_outputs: got %0d words left required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
